keypad_entry_ctrl: RTL and testbench

//  Front end of the profile password store. Collects keypad keystrokes and assembles a 4-digit
//  BCD password plus a profile index. Drives password/selected_profile/write into the store and

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_timer.sv | 26 ++
 rtl/keypad_entry_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - key codes, FSM state encoding and sizing shared by the keypad entry controller
package keypad_pkg;

    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    localparam int PW_DIGITS    = 4;
    localparam int NUM_PROFILES = 4;
    localparam int DIGIT_CNT_W  = $clog2(PW_DIGITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        PROF,
        DIGITS,
        VERIFY,
        OPEN,
        LOCKED
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_timer.sv
// rtl/keypad_timer.sv - loadable down-counter that holds at zero
module keypad_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - keypad password entry, verify/open/program sequencing and lockout
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter int OPEN_CYCLES = 500,
    parameter int RESULT_LAT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        valid,
    output logic [15:0] password,
    output logic [3:0]  selected_profile,
    output logic        write,
    output logic        unlock,
    output logic        lockout,
    output logic [1:0]  fail_cnt
);

    localparam int TMAX = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    // A state that must last N cycles loads N-1; it leaves on the cycle the timer reads zero.
    localparam logic [TW-1:0] VERIFY_LOAD = TW'(RESULT_LAT - 1);
    localparam logic [TW-1:0] OPEN_LOAD   = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCK_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [DIGIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                   prog_q, prog_d;
    logic [15:0]            pw_d;
    logic [3:0]             prof_d;
    logic [1:0]             fail_d;
    logic                   write_d;
    logic                   tmr_load;
    logic [TW-1:0]          tmr_val;
    logic                   tmr_done;
    logic                   key_ok;

    keypad_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

    // Keys arriving during the write strobe are dropped so the store sees a stable password.
    assign key_ok  = key_valid && !write;
    assign unlock  = (state_q == OPEN);
    assign lockout = (state_q == LOCKED);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prog_d   = prog_q;
        pw_d     = password;
        prof_d   = selected_profile;
        fail_d   = fail_cnt;
        write_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        if (write) begin
            pw_d  = '0;
            cnt_d = '0;
        end

        case (state_q)
            IDLE, DIGITS: begin
                if (key_ok) begin
                    if (is_digit(key_code)) begin
                        state_d = DIGITS;
                        if (cnt_q < DIGIT_CNT_W'(PW_DIGITS)) begin
                            pw_d  = {password[11:0], key_code};
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (key_code == KEY_A) begin
                        state_d = PROF;
                    end else if (key_code == KEY_B) begin
                        pw_d    = '0;
                        cnt_d   = '0;
                        prog_d  = 1'b0;
                        state_d = IDLE;
                    end else if (key_code == KEY_C && state_q == DIGITS &&
                                 cnt_q == DIGIT_CNT_W'(PW_DIGITS)) begin
                        if (prog_q) begin
                            write_d = 1'b1;
                            prog_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d  = VERIFY;
                            tmr_load = 1'b1;
                            tmr_val  = VERIFY_LOAD;
                        end
                    end
                end
            end

            PROF: begin
                if (key_ok) begin
                    state_d = IDLE;
                    if (key_code < 4'(NUM_PROFILES)) begin
                        prof_d = key_code;
                        pw_d   = '0;
                        cnt_d  = '0;
                    end else if (key_code == KEY_B) begin
                        pw_d   = '0;
                        cnt_d  = '0;
                        prog_d = 1'b0;
                    end
                end
            end

            VERIFY: begin
                if (tmr_done) begin
                    pw_d  = '0;
                    cnt_d = '0;
                    if (valid) begin
                        fail_d   = '0;
                        state_d  = OPEN;
                        tmr_load = 1'b1;
                        tmr_val  = OPEN_LOAD;
                    end else if (fail_cnt == 2'(MAX_FAIL - 1)) begin
                        fail_d   = fail_cnt + 2'd1;
                        state_d  = LOCKED;
                        tmr_load = 1'b1;
                        tmr_val  = LOCK_LOAD;
                    end else begin
                        fail_d  = fail_cnt + 2'd1;
                        state_d = IDLE;
                    end
                end
            end

            OPEN: begin
                // Expiry takes priority over a key arriving on the same cycle.
                if (tmr_done) begin
                    state_d = IDLE;
                end else if (key_ok && key_code == KEY_D) begin
                    prog_d  = 1'b1;
                    state_d = IDLE;
                end else if (key_ok && key_code == KEY_B) begin
                    pw_d    = '0;
                    cnt_d   = '0;
                    prog_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            LOCKED: begin
                if (tmr_done) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            prog_q           <= 1'b0;
            password         <= '0;
            selected_profile <= '0;
            fail_cnt         <= '0;
            write            <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            prog_q           <= prog_d;
            password         <= pw_d;
            selected_profile <= prof_d;
            fail_cnt         <= fail_d;
            write            <= write_d;
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - scoreboard bench for keypad_entry_ctrl with keystroke-level model
module tb_keypad_entry_ctrl;
    import keypad_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        valid;
    logic [15:0] password;
    logic [3:0]  selected_profile;
    logic        write, unlock, lockout;
    logic [1:0]  fail_cnt;

    always #5 clk = ~clk;

    keypad_entry_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .key_valid        (key_valid),
        .key_code         (key_code),
        .valid            (valid),
        .password         (password),
        .selected_profile (selected_profile),
        .write            (write),
        .unlock           (unlock),
        .lockout          (lockout),
        .fail_cnt         (fail_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Password store environment: two-cycle registered match result.
    logic        env_init = 1'b1;
    logic [15:0] env_store [4];
    logic        v1;
    always @(posedge clk) begin
        if (env_init) begin
            env_store[0] <= 16'h2468;
            env_store[1] <= 16'h1234;
            env_store[2] <= 16'h5555;
            env_store[3] <= 16'h0907;
        end else if (write) begin
            env_store[selected_profile[1:0]] <= password;
        end
        v1    <= (password == env_store[selected_profile[1:0]]);
        valid <= v1;
    end

    // Keystroke-level reference model; verify results are resolved instantly on C.
    localparam int M_IDLE = 0, M_PROF = 1, M_DIGITS = 2, M_OPEN = 3, M_LOCKED = 4;
    int m_st, m_pw, m_cnt, m_prof, m_prog, m_fail;
    int m_store [4];
    bit m_verify, m_commit;
    int q_pw[$], q_prof[$], q_fail[$], q_wr[$], q_open[$], q_lock[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string name, ref int q[$], input int act);
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event %0h, nothing expected", name, act);
        end else begin
            int e = q.pop_front();
            if (act != e) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", name, act, e);
            end
        end
    endtask

    function automatic void model_reset();
        m_st = M_IDLE; m_pw = 0; m_cnt = 0; m_prof = 0; m_prog = 0; m_fail = 0;
        q_pw.delete(); q_prof.delete(); q_fail.delete();
        q_wr.delete(); q_open.delete(); q_lock.delete();
    endfunction

    function automatic void model_step(input int k);
        int old_pw   = m_pw;
        int old_prof = m_prof;
        m_verify = 0;
        m_commit = 0;
        case (m_st)
            M_PROF: begin
                m_st = M_IDLE;
                if (k < NUM_PROFILES) begin
                    m_prof = k; m_pw = 0; m_cnt = 0;
                end else if (k == KEY_B) begin
                    m_pw = 0; m_cnt = 0; m_prog = 0;
                end
            end
            M_OPEN: begin
                if (k == KEY_D) begin
                    m_prog = 1; m_st = M_IDLE;
                end else if (k == KEY_B) begin
                    m_prog = 0; m_st = M_IDLE;
                end
            end
            M_IDLE, M_DIGITS: begin
                if (k <= 9) begin
                    if (m_cnt < 4) begin
                        m_pw = (m_pw * 16 + k) % 65536;
                        m_cnt++;
                    end
                    m_st = M_DIGITS;
                end else if (k == KEY_A) begin
                    m_st = M_PROF;
                end else if (k == KEY_B) begin
                    m_pw = 0; m_cnt = 0; m_prog = 0; m_st = M_IDLE;
                end else if (k == KEY_C && m_st == M_DIGITS && m_cnt == 4) begin
                    m_st = M_IDLE;
                    if (m_prog != 0) begin
                        q_wr.push_back(m_prof * 65536 + m_pw);
                        m_store[m_prof] = m_pw;
                        m_prog = 0;
                        m_commit = 1;
                    end else begin
                        m_verify = 1;
                        if (m_store[m_prof] == m_pw) begin
                            if (m_fail != 0) q_fail.push_back(0);
                            m_fail = 0;
                            m_st = M_OPEN;
                        end else begin
                            m_fail++;
                            q_fail.push_back(m_fail);
                            if (m_fail == 3) begin
                                q_fail.push_back(0);
                                q_lock.push_back(1000 * 4 + 3);
                                m_fail = 0;
                                m_st = M_LOCKED;
                            end
                        end
                    end
                    m_pw = 0; m_cnt = 0;
                end
            end
            default: ;
        endcase
        if (m_pw != old_pw) q_pw.push_back(m_pw);
        if (m_prof != old_prof) q_prof.push_back(m_prof);
    endfunction

    // Monitor: every observable output change is matched against the expected queues.
    bit          mon_en = 0;
    logic [15:0] p_pw;
    logic [3:0]  p_prof;
    logic [1:0]  p_fail;
    logic        p_unl, p_lck;
    int ucnt = 0, lcnt = 0, u_prof = 0, l_fail = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (password != p_pw) pop_cmp("password", q_pw, int'(password));
            if (selected_profile != p_prof) pop_cmp("profile", q_prof, int'(selected_profile));
            if (fail_cnt != p_fail) pop_cmp("fail_cnt", q_fail, int'(fail_cnt));
            if (write) pop_cmp("write", q_wr, int'(selected_profile) * 65536 + int'(password));
            if (unlock && !p_unl) begin
                ucnt = 0;
                u_prof = int'(selected_profile);
                check("open_password_cleared", int'(password), 0);
            end
            if (unlock) ucnt++;
            if (!unlock && p_unl) pop_cmp("open_len_prof", q_open, ucnt * 16 + u_prof);
            if (lockout && !p_lck) begin
                lcnt = 0;
                l_fail = int'(fail_cnt);
            end
            if (lockout) lcnt++;
            if (!lockout && p_lck) pop_cmp("lock_len_fail", q_lock, lcnt * 4 + l_fail);
        end else begin
            ucnt = 0;
            lcnt = 0;
        end
        p_pw = password; p_prof = selected_profile; p_fail = fail_cnt;
        p_unl = unlock; p_lck = lockout;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_key(input int k, input int gap);
        key_code  = 4'(k);
        key_valid = 1'b1;
        model_step(k);
        @(negedge clk);
        key_valid = 1'b0;
        idle(gap);
    endtask

    task automatic wait_sig(input int which, input logic lvl, input int limit, input string name);
        int i;
        checks++;
        for (i = 0; i < limit; i++) begin
            if (((which == 0) ? unlock : lockout) == lvl) break;
            @(negedge clk);
        end
        if (i == limit) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, required level %0d", name, limit, lvl);
        end
    endtask

    // mode 0: let OPEN expire; 1: B in unlock cycle k; 2: D in unlock cycle k (k=500 collides with expiry)
    task automatic do_open(input int mode, input int k);
        int dur;
        wait_sig(0, 1'b1, 10, "unlock_rise");
        dur = (mode == 0 || k >= 500) ? 500 : k;
        q_open.push_back(dur * 16 + m_prof);
        if (mode == 0) begin
            wait_sig(0, 1'b0, 600, "unlock_fall");
            m_st = M_IDLE;
        end else begin
            idle(k - 1);
            if (k >= 500) m_st = M_IDLE;
            send_key((mode == 1) ? KEY_B : KEY_D, 1);
        end
    endtask

    task automatic do_lock();
        wait_sig(1, 1'b1, 10, "lock_rise");
        for (int i = 0; i < 6; i++) send_key($urandom_range(0, 15), 2);
        wait_sig(1, 1'b0, 1100, "lock_fall");
        m_st = M_IDLE;
    endtask

    task automatic key(input int k);
        int r;
        send_key(k, (k == KEY_C) ? 0 : $urandom_range(0, 2));
        if (m_verify) begin
            if (m_st == M_OPEN) begin
                r = $urandom_range(0, 3);
                case (r)
                    0: do_open(0, 0);
                    1: do_open(1, $urandom_range(1, 20));
                    2: do_open(2, $urandom_range(1, 20));
                    default: do_open(2, $urandom_range(499, 500));
                endcase
            end else if (m_st == M_LOCKED) begin
                do_lock();
            end else begin
                idle(3);
            end
        end else if (m_commit) begin
            idle(2);
        end
    endtask

    task automatic enter(input int v);
        for (int i = 3; i >= 0; i--) key((v >> (4 * i)) & 15);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_password"}, int'(password), 0);
        check({tag, "_profile"}, int'(selected_profile), 0);
        check({tag, "_write"}, int'(write), 0);
        check({tag, "_unlock"}, int'(unlock), 0);
        check({tag, "_lockout"}, int'(lockout), 0);
        check({tag, "_fail_cnt"}, int'(fail_cnt), 0);
    endtask

    task automatic async_reset(input string tag);
        mon_en = 0;
        #2 rst = 1'b0;
        #1 check_zero(tag);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int saved [4];
        int r;
        m_store[0] = 16'h2468; m_store[1] = 16'h1234;
        m_store[2] = 16'h5555; m_store[3] = 16'h0907;
        model_reset();

        #2 rst = 1'b0;
        #1 check_zero("reset");
        @(negedge clk);
        env_init = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1;
        idle(2);

        key(KEY_A); key(7);
        check("profile_after_A7", int'(selected_profile), 0);

        key(KEY_A); key(1);
        check("profile_after_A1", int'(selected_profile), 1);
        enter(16'h1234);
        send_key(KEY_C, 0);
        do_open(0, 0);
        check("fail_cnt_after_open", int'(fail_cnt), 0);

        for (int i = 0; i < 3; i++) begin
            enter(16'h0000);
            key(KEY_C);
        end
        check("fail_cnt_after_lock", int'(fail_cnt), 0);

        enter(16'h1234);
        send_key(KEY_C, 0);
        do_open(2, 10);
        enter(16'h9876);
        key(KEY_C);
        enter(16'h9876);
        send_key(KEY_C, 0);
        do_open(1, 5);

        key(1); key(2); key(3); key(KEY_C); key(4); key(5);
        check("password_saturated", int'(password), 16'h1234);
        key(KEY_B);
        check("password_cleared_by_B", int'(password), 0);

        for (int s = 0; s < 40; s++) begin
            r = $urandom_range(0, 2);
            if (r == 0) begin
                enter(m_store[m_prof]);
                key(KEY_C);
            end else if (r == 1) begin
                for (int d = 0; d < 4; d++) key($urandom_range(0, 9));
                key(KEY_C);
            end else begin
                for (int d = 0; d < int'($urandom_range(1, 6)); d++) key($urandom_range(0, 15));
            end
        end

        key(KEY_B);
        enter(m_store[m_prof]);
        send_key(KEY_C, 0);
        async_reset("rst_in_verify");
        idle(10);
        check("no_unlock_after_verify_reset", int'(unlock), 0);

        enter(m_store[m_prof]);
        send_key(KEY_C, 0);
        do_open(2, 3);
        saved = m_store;
        enter(16'h4321);
        send_key(KEY_C, 0);
        check("write_pulse_before_reset", int'(write), 1);
        async_reset("rst_in_write");
        m_store = saved;
        idle(10);
        check("no_write_after_reset", int'(write), 0);
        enter(16'h2468);
        send_key(KEY_C, 0);
        do_open(1, 4);

        idle(5);
        check("q_pw_empty", q_pw.size(), 0);
        check("q_prof_empty", q_prof.size(), 0);
        check("q_fail_empty", q_fail.size(), 0);
        check("q_wr_empty", q_wr.size(), 0);
        check("q_open_empty", q_open.size(), 0);
        check("q_lock_empty", q_lock.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
